icache_sa: RTL
==============

Name: icache_sa

Overview:
- Parametrised successor to the direct-mapped, one-word-per-line instruction cache.
- 2-way set-associative, multi-word lines, one LRU bit per set, word-by-word line refill from the memory controller.
- Adds a whole-cache flush and a mispredict abort (clr) that cancels any refill in flight.
- Sits between the IF stage and the memory controller.

Parameters:
- ADDR_W, 32, address width. Tag width is ADDR_W-2-WORD_B-INDEX_B.
- SETS, 16, number of sets. Power of two, at least 2. INDEX_B = $clog2(SETS).
- LINE_WORDS, 4, 32-bit words per line. Power of two, at least 2. WORD_B = $clog2(LINE_WORDS).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global ready; when low, the block is frozen
- clr  in  1  mispredict clear; aborts the current refill and any pending response
- flush  in  1  invalidate all lines and clear all LRU bits
- if_req  in  1  fetch request, level-sensitive
- if_pc  in  ADDR_W  fetch address; bits [1:0] are ignored
- if_valid  out  1  one-cycle pulse; if_inst is valid
- if_inst  out  32  fetched instruction
- mem_req  out  1  word read request; held high until mem_done
- mem_addr  out  ADDR_W  word-aligned read address
- mem_done  in  1  one-cycle pulse; mem_data is valid
- mem_data  in  32  returned word

Behaviour:
- Address split:
  - pc[1:0] byte offset, ignored
  - pc[WORD_B+1:2] word
  - pc[INDEX_B+WORD_B+1:WORD_B+2] index
  - remaining high bits form the tag
- Reset values: all valid bits 0, all LRU bits 0, state IDLE, if_valid 0, if_inst 0, mem_req 0, mem_addr 0, refill counter 0.
- Priority per cycle: rst > flush > clr > !rdy > normal operation.
- Two states, IDLE and REFILL.
- IDLE, if_req high, hit in way w (valid and tag match):
  - if_valid=1 next cycle, with the word from the line.
  - LRU[set] <= ~w.
  - Back-to-back hits give one response per cycle.
- IDLE, if_req high, miss:
  - Choose the victim: way0 if it is invalid, else way1 if it is invalid, else the way given by LRU[set].
  - Clear the victim's valid bit immediately.
  - Latch the tag and index of if_pc, set cnt=0, go to REFILL.
  - if_valid=0 next cycle.
- IDLE, if_req low: if_valid=0 next cycle.
- REFILL:
  - mem_req=1 and mem_addr={tag,index,cnt,2'b00}, registered.
  - The first request appears the cycle after the miss is detected.
  - On mem_done, write mem_data to word cnt of the victim way, then cnt++ and mem_addr advances on the next cycle. mem_req stays high between words.
  - On mem_done with cnt==LINE_WORDS-1:
    - write the word, set the victim's valid bit and tag, set LRU[set] <= ~victim
    - mem_req=0 and cnt=0 next cycle, go to IDLE
  - if_req and if_pc are not looked at while in REFILL.
  - The refill always completes for the latched line, even if if_pc changes.
  - On return to IDLE the current if_pc is looked up again. So if the last mem_done is at cycle T, if_valid for the same pc is at T+2.
- clr:
  - Next cycle: if_valid=0, mem_req=0, state IDLE, cnt=0.
  - An aborted victim stays invalid. Partially written data is never returned.
  - A mem_done in the same cycle as clr is discarded.
- flush:
  - Clears all valid and LRU bits.
  - Otherwise behaves like clr, including aborting a refill.
- rdy low:
  - No state, array, LRU or counter change.
  - if_valid=0.
  - mem_req and mem_addr hold their values.
  - mem_done is ignored.
- mem_done while in IDLE is ignored.

Test Plan:
All scenarios use SETS=16, LINE_WORDS=4 (index is pc[7:4]).
1. Cold miss:
   - Stimulus: if_pc=0x1000; memory returns 0xA0,0xA1,0xA2,0xA3.
   - Response: mem_addr steps 0x1000→0x1004→0x1008→0x100C. Last mem_done at T gives if_valid=1 and if_inst=0xA0 at T+2.
   - Then if_pc=0x100C: if_inst=0xA3 one cycle later, mem_req stays 0.
2. Hit stream:
   - Stimulus: pc=0x1000,0x1004,0x1008 on consecutive cycles after scenario 1.
   - Response: three consecutive if_valid pulses with 0xA0,0xA1,0xA2, no mem_req.
3. LRU eviction:
   - Stimulus: fill 0x1000, fill 0x2000, hit 0x1000, then miss 0x3000.
   - Response: 0x3000 replaces 0x2000. A later 0x1000 hits; 0x2000 misses and issues mem_addr 0x2000.
4. clr mid-refill:
   - Stimulus: clr after 2 of 4 mem_done for 0x1000.
   - Response: mem_req=0 next cycle. A new request to 0x1004 misses and refills from 0x1000 with all 4 words. if_valid is never asserted before the refill completes.
5. Flush:
   - Stimulus: after scenario 2, pulse flush, then request 0x1000.
   - Response: miss, mem_req=1 with mem_addr=0x1000.
6. rdy stall:
   - Stimulus: rdy=0 for 3 cycles mid-refill, mem_done pulsed during the stall.
   - Response: mem_addr unchanged, cnt unchanged, if_valid=0. The refill resumes when rdy returns and still requests all 4 words.

Source files
------------

// File: rtl/icache_sa_if.sv
// Fetch-side and memory-side signal bundle for the set-associative instruction cache.
// The cache takes the slave view; the IF stage / memory controller side takes the master view.
interface icache_sa_if #(
    parameter int ADDR_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_pc;
    logic              if_valid;
    logic [31:0]       if_inst;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_done;
    logic [31:0]       mem_data;

    modport slave (
        input  if_req, if_pc, mem_done, mem_data,
        output if_valid, if_inst, mem_req, mem_addr
    );

    modport master (
        output if_req, if_pc, mem_done, mem_data,
        input  if_valid, if_inst, mem_req, mem_addr
    );
endinterface

// File: rtl/icache_sa.sv
// 2-way set-associative instruction cache with multi-word lines, per-set LRU bit,
// word-by-word refill, whole-cache flush and mispredict abort (clr).
module icache_sa #(
    parameter int ADDR_W     = 32,
    parameter int SETS       = 16,
    parameter int LINE_WORDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         rdy,
    input  logic         clr,
    input  logic         flush,
    icache_sa_if.slave   bus
);
    localparam int INDEX_B = $clog2(SETS);
    localparam int WORD_B  = $clog2(LINE_WORDS);
    localparam int TAG_W   = ADDR_W - 2 - WORD_B - INDEX_B;
    localparam logic [WORD_B-1:0] CNT_ONE  = WORD_B'(1);
    localparam logic [WORD_B-1:0] CNT_LAST = WORD_B'(LINE_WORDS - 1);

    typedef enum logic {IDLE, REFILL} state_t;

    state_t state, state_nxt;

    logic [SETS-1:0]  vld [2];
    logic [SETS-1:0]  lru;
    logic [TAG_W-1:0] tags [2][SETS];
    logic [31:0]      data [2][SETS][LINE_WORDS];

    logic [TAG_W-1:0]   fill_tag;
    logic [INDEX_B-1:0] fill_idx;
    logic               vic_way;
    logic [WORD_B-1:0]  cnt;
    logic [WORD_B-1:0]  cnt_nxt;

    logic [WORD_B-1:0]  pc_word;
    logic [INDEX_B-1:0] pc_idx;
    logic [TAG_W-1:0]   pc_tag;
    logic               hit0, hit1, hit, victim;
    logic               do_hit, do_miss, do_word, do_last;
    logic               unused_pc_bits;

    assign pc_word = bus.if_pc[WORD_B+1:2];
    assign pc_idx  = bus.if_pc[INDEX_B+WORD_B+1:WORD_B+2];
    assign pc_tag  = bus.if_pc[ADDR_W-1:INDEX_B+WORD_B+2];
    assign unused_pc_bits = ^bus.if_pc[1:0];

    assign hit0    = vld[0][pc_idx] && (tags[0][pc_idx] == pc_tag);
    assign hit1    = vld[1][pc_idx] && (tags[1][pc_idx] == pc_tag);
    assign hit     = hit0 || hit1;
    // Fill an empty way before evicting; LRU only decides when both ways are live.
    assign victim  = !vld[0][pc_idx] ? 1'b0 :
                     !vld[1][pc_idx] ? 1'b1 : lru[pc_idx];
    assign cnt_nxt = cnt + CNT_ONE;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        do_hit    = 1'b0;
        do_miss   = 1'b0;
        do_word   = 1'b0;
        do_last   = 1'b0;
        if (flush || clr) begin
            state_nxt = IDLE;
        end else if (rdy) begin
            case (state)
                IDLE: begin
                    if (bus.if_req) begin
                        if (hit) begin
                            do_hit = 1'b1;
                        end else begin
                            do_miss   = 1'b1;
                            state_nxt = REFILL;
                        end
                    end
                end
                REFILL: begin
                    if (bus.mem_done) begin
                        do_word = 1'b1;
                        if (cnt == CNT_LAST) begin
                            do_last   = 1'b1;
                            state_nxt = IDLE;
                        end
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Control state, valid/LRU bits and the registered bus outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld[0]       <= '0;
            vld[1]       <= '0;
            lru          <= '0;
            cnt          <= '0;
            bus.if_valid <= 1'b0;
            bus.if_inst  <= '0;
            bus.mem_req  <= 1'b0;
            bus.mem_addr <= '0;
        end else if (flush || clr) begin
            if (flush) begin
                vld[0] <= '0;
                vld[1] <= '0;
                lru    <= '0;
            end
            cnt          <= '0;
            bus.if_valid <= 1'b0;
            bus.mem_req  <= 1'b0;
        end else if (!rdy) begin
            bus.if_valid <= 1'b0;
        end else begin
            bus.if_valid <= do_hit;
            if (do_hit) begin
                bus.if_inst <= data[hit1][pc_idx][pc_word];
                lru[pc_idx] <= ~hit1;
            end
            if (do_miss) begin
                // Victim is invalidated now so an aborted refill never leaves a half-filled line visible.
                vld[victim][pc_idx] <= 1'b0;
                vic_way      <= victim;
                fill_tag     <= pc_tag;
                fill_idx     <= pc_idx;
                cnt          <= '0;
                bus.mem_req  <= 1'b1;
                bus.mem_addr <= {pc_tag, pc_idx, {WORD_B{1'b0}}, 2'b00};
            end
            if (do_word) begin
                if (do_last) begin
                    vld[vic_way][fill_idx] <= 1'b1;
                    lru[fill_idx]          <= ~vic_way;
                    cnt                    <= '0;
                    bus.mem_req            <= 1'b0;
                end else begin
                    cnt          <= cnt_nxt;
                    bus.mem_addr <= {fill_tag, fill_idx, cnt_nxt, 2'b00};
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && do_word) begin
            data[vic_way][fill_idx][cnt] <= bus.mem_data;
            if (do_last) tags[vic_way][fill_idx] <= fill_tag;
        end
    end
endmodule
